// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered memory load returns onto the
// register file's single write port. Writes to protected registers are filtered out.
// Latency: ALU result is written 1 cycle after it is accepted; a memory return
// takes at least 2 cycles (push, then pop, then output register).
// Backpressure: o_alu_ready drops when the lane is disabled, in reset, or when
// memory is forced. o_mem_ready drops when the FIFO is full.
// Ports: i_clk/i_rst (sync, active-high), i_enable, ALU valid/ready/rd/data,
//        MEM valid/ready/rd/data, o_reg_write/o_wb_rd/o_wb_data, o_fifo_count, o_idle.
// Optional: define WB_STATS_EN to add o_drop_count and o_alu_stall_count.
module writeback_arbiter #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7,
  parameter int MEM_FIFO_DEPTH      = 4,
  parameter int STARVE_LIMIT        = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  input  logic                                i_alu_valid,
  output logic                                o_alu_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0]      i_alu_rd,
  input  logic [DATA_WIDTH-1:0]               i_alu_data,
  input  logic                                i_mem_valid,
  output logic                                o_mem_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0]      i_mem_rd,
  input  logic [DATA_WIDTH-1:0]               i_mem_data,
  output logic                                o_reg_write,
  output logic [DATA_REG_ADDR_WIDTH-1:0]      o_wb_rd,
  output logic [DATA_WIDTH-1:0]               o_wb_data,
  output logic [$clog2(MEM_FIFO_DEPTH):0]     o_fifo_count,
  output logic                                o_idle
`ifdef WB_STATS_EN
  ,
  output logic [15:0]                         o_drop_count,
  output logic [15:0]                         o_alu_stall_count
`endif
);

  localparam int PW = $clog2(MEM_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = DATA_REG_ADDR_WIDTH;

  // Memory-return FIFO storage and pointers (pointers wrap naturally: depth is 2^PW)
  logic [RW-1:0]         r_fifo_rd   [MEM_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [MEM_FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_reg_write;
  logic [RW-1:0]         r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic                  w_m;
  logic                  w_force_mem;
  logic                  w_push;
  logic                  w_mem_grant;
  logic                  w_alu_grant;
  logic                  w_grant;
  logic [RW-1:0]         w_win_rd;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_win_keep;

  assign w_m         = (r_count != '0);
  assign w_force_mem = w_m && (r_starve_cnt == SW'(STARVE_LIMIT));

  // Ready signals come from registered state only, so a same-cycle pop never
  // opens a slot for a push.
  assign o_alu_ready = i_enable && !i_rst && !w_force_mem;
  assign o_mem_ready = !i_rst && (r_count < CW'(MEM_FIFO_DEPTH));
  assign w_push      = i_mem_valid && o_mem_ready;

  assign w_mem_grant = i_enable && w_m && (!i_alu_valid || w_force_mem);
  assign w_alu_grant = i_enable && !w_mem_grant && i_alu_valid;
  assign w_grant     = w_mem_grant || w_alu_grant;

  assign w_win_rd    = w_mem_grant ? r_fifo_rd[r_rd_ptr]   : i_alu_rd;
  assign w_win_data  = w_mem_grant ? r_fifo_data[r_rd_ptr] : i_alu_data;
  // Only R4..R27 are writable; other indices consume the grant but are not written.
  assign w_win_keep  = (w_win_rd >= RW'(4)) && (w_win_rd <= RW'(27));

  // FIFO storage needs no reset: entries are only read when r_count says they are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= i_mem_rd;
      r_fifo_data[r_wr_ptr] <= i_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_reg_write  <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_mem_grant) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_mem_grant) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_mem_grant) begin
        r_count <= r_count - CW'(1);
      end

      // Counter holds while the lane is frozen.
      if (i_enable) begin
        if (w_mem_grant || !w_m) begin
          r_starve_cnt <= '0;
        end else if (w_alu_grant && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
          r_starve_cnt <= r_starve_cnt + SW'(1);
        end
      end

      r_reg_write <= w_grant && w_win_keep;
      if (w_grant) begin
        r_wb_rd   <= w_win_rd;
        r_wb_data <= w_win_data;
      end
    end
  end

  assign o_reg_write  = r_reg_write;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_data    = r_wb_data;
  assign o_fifo_count = r_count;
  assign o_idle       = (r_count == '0) && !r_reg_write;

`ifdef WB_STATS_EN
  logic [15:0] r_drop_count;
  logic [15:0] r_alu_stall_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_count      <= '0;
      r_alu_stall_count <= '0;
    end else begin
      if (w_grant && !w_win_keep && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (i_alu_valid && !o_alu_ready && (r_alu_stall_count != 16'hFFFF)) begin
        r_alu_stall_count <= r_alu_stall_count + 16'd1;
      end
    end
  end

  assign o_drop_count      = r_drop_count;
  assign o_alu_stall_count = r_alu_stall_count;
`endif

endmodule
